// File: rtl/ps2_rx_frame_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, prefix codes,
// frame geometry and the odd-parity helper.
package ps2_rx_frame_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes emitted by the keyboard ahead of extended / break codes
  localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
  localparam logic [7:0] PS2_CODE_BREAK = 8'hF0;

  // Number of data bits in one device-to-host frame
  localparam int unsigned PS2_DATA_BITS = 8;

  // True when the data byte plus its parity bit has an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
    return ^{data_byte, par_bit};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser for the raw PS/2 clock followed by a stability filter.
// The filtered level only moves after FILTER_LEN consecutive samples that
// disagree with it; a single-cycle pulse marks each accepted 1->0 transition.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic raw_in,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             meta_r;
  logic             sync_r;
  logic             filt_r;
  logic             fall_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous pin into the clk_sys domain (idle level is high)
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= raw_in;
      sync_r <= meta_r;
    end
  end

  // Accept a new level only after it has persisted; flag accepted falling edges
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= 1'b1;
      cnt_r  <= {CNT_W{1'b0}};
      fall_r <= 1'b0;
    end else if (sync_r == filt_r) begin
      cnt_r  <= {CNT_W{1'b0}};
      fall_r <= 1'b0;
    end else if (cnt_r == CNT_W'(FILTER_LEN - 1)) begin
      filt_r <= sync_r;
      cnt_r  <= {CNT_W{1'b0}};
      fall_r <= filt_r & ~sync_r;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      fall_r <= 1'b0;
    end
  end

  assign fall = fall_r;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver. Deframes start / 8 data (LSB first) /
// odd parity / stop, and reports good bytes, parity errors and framing or
// timeout errors as single-cycle pulses.
// Optional feature macro: PS2_BREAK_DECODE_EN -- absorbs E0/F0 prefixes and
// reports them as is_ext/is_break alongside the following scan code.
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy,
  output logic       is_break,
  output logic       is_ext
);

  logic [1:0]           rst_sync_r;
  logic                 core_rst_n_s;
  logic                 fall_s;
  logic                 data_meta_r;
  logic                 data_sync_r;

  ps2_state_e           state_r,     state_s;
  logic [2:0]           bit_cnt_r,   bit_cnt_s;
  logic [7:0]           shift_r,     shift_s;
  logic                 par_r,       par_s;
  logic [TIMEOUT_W-1:0] tmo_cnt_r,   tmo_cnt_s;
  logic [7:0]           scan_code_r, scan_code_s;
  logic                 valid_r,     valid_s;
  logic                 perr_r,      perr_s;
  logic                 ferr_r,      ferr_s;
`ifdef PS2_BREAK_DECODE_EN
  logic                 is_break_r,  is_break_s;
  logic                 is_ext_r,    is_ext_s;
  logic                 pend_brk_r,  pend_brk_s;
  logic                 pend_ext_r,  pend_ext_s;
`endif

  // Reset asserts immediately, releases synchronously to clk_sys
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign core_rst_n_s = rst_sync_r[1];

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_sys (clk_sys),
    .rst_n   (core_rst_n_s),
    .raw_in  (ps2_clk),
    .fall    (fall_s)
  );

  // Data pin only needs metastability protection; it is sampled on filtered clock falls
  always_ff @(posedge clk_sys or negedge core_rst_n_s) begin
    if (!core_rst_n_s) begin
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Next-state, datapath and output-pulse decode for the frame FSM
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    par_s       = par_r;
    tmo_cnt_s   = tmo_cnt_r;
    scan_code_s = scan_code_r;
    valid_s     = 1'b0;
    perr_s      = 1'b0;
    ferr_s      = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
    is_break_s  = is_break_r;
    is_ext_s    = is_ext_r;
    pend_brk_s  = pend_brk_r;
    pend_ext_s  = pend_ext_r;
`endif

    case (state_r)
      ST_IDLE: begin
        tmo_cnt_s = {TIMEOUT_W{1'b0}};
        if (fall_s && !data_sync_r) begin
          state_s   = ST_DATA;
          bit_cnt_s = 3'd0;
          shift_s   = 8'h00;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_s   = {data_sync_r, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'(PS2_DATA_BITS - 1)) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_s   = data_sync_r;
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_s = ST_IDLE;
          if (!data_sync_r) begin
            ferr_s = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            pend_brk_s = 1'b0;
            pend_ext_s = 1'b0;
`endif
          end else if (!odd_parity_ok(shift_r, par_r)) begin
            perr_s = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            pend_brk_s = 1'b0;
            pend_ext_s = 1'b0;
`endif
          end else begin
`ifdef PS2_BREAK_DECODE_EN
            if (shift_r == PS2_CODE_EXT) begin
              pend_ext_s = 1'b1;
            end else if (shift_r == PS2_CODE_BREAK) begin
              pend_brk_s = 1'b1;
            end else begin
              scan_code_s = shift_r;
              valid_s     = 1'b1;
              is_ext_s    = pend_ext_r;
              is_break_s  = pend_brk_r;
              pend_ext_s  = 1'b0;
              pend_brk_s  = 1'b0;
            end
`else
            scan_code_s = shift_r;
            valid_s     = 1'b1;
`endif
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Inter-edge watchdog: restarts on every fall, only runs mid-frame
    if (state_r != ST_IDLE) begin
      if (fall_s) begin
        tmo_cnt_s = {TIMEOUT_W{1'b0}};
      end else if (tmo_cnt_r == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt_s = {TIMEOUT_W{1'b0}};
        state_s   = ST_IDLE;
        shift_s   = 8'h00;
        bit_cnt_s = 3'd0;
        ferr_s    = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
        pend_brk_s = 1'b0;
        pend_ext_s = 1'b0;
`endif
      end else begin
        tmo_cnt_s = tmo_cnt_r + TIMEOUT_W'(1);
      end
    end else begin
      tmo_cnt_s = {TIMEOUT_W{1'b0}};
    end
  end

  // Frame state, datapath and registered outputs
  always_ff @(posedge clk_sys or negedge core_rst_n_s) begin
    if (!core_rst_n_s) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_r       <= 1'b0;
      tmo_cnt_r   <= {TIMEOUT_W{1'b0}};
      scan_code_r <= 8'h00;
      valid_r     <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      is_break_r  <= 1'b0;
      is_ext_r    <= 1'b0;
      pend_brk_r  <= 1'b0;
      pend_ext_r  <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      par_r       <= par_s;
      tmo_cnt_r   <= tmo_cnt_s;
      scan_code_r <= scan_code_s;
      valid_r     <= valid_s;
      perr_r      <= perr_s;
      ferr_r      <= ferr_s;
`ifdef PS2_BREAK_DECODE_EN
      is_break_r  <= is_break_s;
      is_ext_r    <= is_ext_s;
      pend_brk_r  <= pend_brk_s;
      pend_ext_r  <= pend_ext_s;
`endif
    end
  end

  assign scan_code  = scan_code_r;
  assign code_valid = valid_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign rx_busy    = (state_r != ST_IDLE);
`ifdef PS2_BREAK_DECODE_EN
  assign is_break   = is_break_r;
  assign is_ext     = is_ext_r;
`else
  assign is_break   = 1'b0;
  assign is_ext     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed frames plus randomized
// frames compared against a byte-level reference model of the receiver.
module tb_ps2_rx_frame;

  localparam int FL = 8;
  localparam int TO = 400;

  logic       clk_sys  = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, parity_err, frame_err, rx_busy, is_break, is_ext;

  always #5 clk_sys = ~clk_sys;

  ps2_rx_frame #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (17)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy),
    .is_break   (is_break),
    .is_ext     (is_ext)
  );

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0;

  // reference model state
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0, m_brk = 1'b0, m_pext = 1'b0, m_pbrk = 1'b0;
  int         e_valid, e_perr, e_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pulse monitor, sampled away from the active edge
  always @(negedge clk_sys) begin
    if (code_valid === 1'b1) n_valid++;
    if (parity_err === 1'b1) n_perr++;
    if (frame_err === 1'b1)  n_ferr++;
    if (int'(code_valid === 1'b1) + int'(parity_err === 1'b1) + int'(frame_err === 1'b1) > 1) n_multi++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(2);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      ps2_clk = 1'b1;
    end
    wait_cyc(12);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(6);
  endtask

  // kind: 0 good, 1 bad parity, 2 stop bit low; nbits < 11 gives a truncated frame
  task automatic send_frame(input logic [7:0] b, input int kind, input int glitch_at, input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b);
    if (kind == 1) par = ~par;
    bits = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_at);
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  // byte-level reference: what one complete frame should produce
  task automatic model_frame(input logic [7:0] b, input int kind);
    e_valid = 0; e_perr = 0; e_ferr = 0;
    if (kind == 2) begin
      e_ferr = 1; m_pext = 1'b0; m_pbrk = 1'b0;
    end else if (kind == 1) begin
      e_perr = 1; m_pext = 1'b0; m_pbrk = 1'b0;
    end else begin
`ifdef PS2_BREAK_DECODE_EN
      if (b == 8'hE0) m_pext = 1'b1;
      else if (b == 8'hF0) m_pbrk = 1'b1;
      else begin
        e_valid = 1; m_code = b; m_ext = m_pext; m_brk = m_pbrk;
        m_pext = 1'b0; m_pbrk = 1'b0;
      end
`else
      e_valid = 1; m_code = b;
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"}, scan_code, m_code);
    check({tag, "_ext"}, is_ext, m_ext);
    check({tag, "_brk"}, is_break, m_brk);
    check({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input int kind, input int glitch_at);
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(b, kind, glitch_at, 11);
    model_frame(b, kind);
    check({tag, "_nvalid"}, n_valid - v0, e_valid);
    check({tag, "_nperr"}, n_perr - p0, e_perr);
    check({tag, "_nferr"}, n_ferr - f0, e_ferr);
    check_outputs(tag);
  endtask

  initial begin
    int v0, p0, f0;
    logic [7:0] rb;
    int kind;

    wait_cyc(3);
    check("rst_code", scan_code, 8'h00);
    check("rst_pulses", {code_valid, parity_err, frame_err}, 3'b000);
    check("rst_busy_ext_brk", {rx_busy, is_ext, is_break}, 3'b000);
    rst_n = 1'b1;
    wait_cyc(10);

    do_frame("good1c", 8'h1C, 0, -1);
    do_frame("par1c", 8'h1C, 1, -1);
    do_frame("stop1c", 8'h1C, 2, -1);

    // truncated frame left idle past the watchdog
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h5A, 0, -1, 6);
    check("tmo_busy_mid", rx_busy, 1'b1);
    wait_cyc(TO + 100);
    m_pext = 1'b0; m_pbrk = 1'b0;
    check("tmo_nferr", n_ferr - f0, 1);
    check("tmo_nvalid", n_valid - v0, 0);
    check("tmo_nperr", n_perr - p0, 0);
    check_outputs("tmo");
    do_frame("after_tmo32", 8'h32, 0, -1);

    do_frame("glitch1c", 8'h1C, 0, 4);

    do_frame("pfx_e0", 8'hE0, 0, -1);
    do_frame("pfx_f0", 8'hF0, 0, -1);
    do_frame("pfx_75", 8'h75, 0, -1);
    do_frame("plain_14", 8'h14, 0, -1);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 5))
        0:       kind = 1;
        1:       kind = 2;
        default: kind = 0;
      endcase
      do_frame($sformatf("rnd%0d", i), rb, kind, -1);
    end

    // reset in the middle of a frame
    send_frame(8'h29, 0, -1, 5);
    rst_n = 1'b0;
    #1;
    m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_pext = 1'b0; m_pbrk = 1'b0;
    check("midrst_code", scan_code, 8'h00);
    check("midrst_pulses", {code_valid, parity_err, frame_err}, 3'b000);
    check("midrst_busy_ext_brk", {rx_busy, is_ext, is_break}, 3'b000);
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(10);
    do_frame("post_rst29", 8'h29, 0, -1);

    check("multi_flag_cycles", n_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
